acc_alu: RTL and testbench
==========================

# acc_alu

Parametrised accumulator ALU; successor to the 2-bit breadboard accumulator. A single WIDTH-bit accumulator is combined with input operand A under a 4-bit opcode, with carry/zero/overflow flags. Requests are accepted through a valid/ready handshake. MUL is a multi-cycle shift-add operation that holds off new requests while it runs. The block sits between the opcode/operand source (testbench or command decoder) and any consumer of the accumulator value C.

## Interface
- WIDTH, 8, accumulator and operand width in bits; minimum 2.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- op_valid  input  1  opcode/A presented this cycle
- op_ready  output  1  block can accept; equals !busy
- opcode  input  4  operation select
- A  input  WIDTH  operand
- C  output  WIDTH  accumulator value (registered)
- carry  output  1  carry/borrow/shift-out flag (registered)
- overflow  output  1  signed overflow flag (registered)
- zero  output  1  combinational (C == 0)
- busy  output  1  MUL in progress
- done  output  1  one-cycle pulse on the cycle after any accepted op's result is written

Clock and reset: one clock, clk. Reset rst is synchronous and active-high.

## Operation
- Accept: an op is accepted on a rising edge where op_valid && op_ready. With op_valid low, nothing changes.
- Opcodes (acc = C):
  - 0000 NOOP: acc and all flags unchanged.
  - 0001 RESET: acc, carry and overflow go to 0.
  - 0010 LOAD: acc = A.
  - 0101 ADD: {carry, acc} = acc + A.
  - 0110 SUB: acc = acc - A; carry = 1 iff acc >= A (unsigned, no borrow).
  - 0111 ADDC: {carry, acc} = acc + A + carry.
  - 1001 AND, 1010 OR, 1011 XOR: bitwise with A.
  - 1100 NOT: acc = ~acc (A ignored).
  - 1101 SHL: acc << 1; carry = old acc[WIDTH-1].
  - 1110 SHR: logical shift right; carry = old acc[0].
  - 1000 MUL: acc = low WIDTH bits of acc*A (unsigned); carry = 1 iff any upper product bit is nonzero.
  - 0011, 0100, 1111: treated as NOOP.
- Flag rules:
  - overflow is set by ADD, SUB and ADDC only, using two's-complement sign rules. ADD/ADDC overflow when both operand signs are equal and the result sign differs. SUB overflows when the operand signs differ and the result sign differs from acc.
  - All other writing ops (LOAD, logic, NOT, shifts, MUL) clear overflow.
  - LOAD and the logic ops also clear carry.
  - NOOP and undefined opcodes leave all flags unchanged.
- MUL state machine:
  - States: IDLE and MUL.
  - IDLE→MUL on an accepted MUL. At acceptance, the multiplicand (acc) and multiplier (A) are latched, and a 2·WIDTH-bit product register and a bit counter are cleared.
  - In MUL, each cycle performs one shift-add step on one multiplier bit (LSB first); the counter increments.
  - After WIDTH steps, acc and carry are written, overflow is cleared, and the machine returns to IDLE.
  - C holds its old value throughout MUL. busy = 1 while in the MUL state.

## Timing
- Reset values: C = 0, carry = 0, overflow = 0, zero = 1, busy = 0, op_ready = 1, done = 0. The state machine goes to IDLE.
- Single-cycle ops: accepted at edge N; C and flags are updated at edge N; done = 1 during cycle N+1. Back-to-back accepts are allowed every cycle.
- MUL: accepted at edge N; busy/op_ready change at edge N; the result is written at edge N+WIDTH; busy drops at the same edge; done pulses in the following cycle.
  - The next op can be accepted at edge N+WIDTH+1.
  - op_valid held high while op_ready = 0 is ignored and is not queued.
- rst has priority over everything.
  - rst during MUL aborts it: no late result write, busy = 0 on the next cycle.
  - An op presented in the same cycle as rst is discarded.
- Arithmetic wraps modulo 2^WIDTH; carry captures the bit lost to the wrap.

## Test plan
- Overflow: rst; LOAD 0x7F; ADD 0x01 → C = 0x80, overflow = 1, carry = 0, zero = 0. Then AND 0x00 → C = 0x00, overflow = 0, zero = 1.
- Carry chain: LOAD 0xFF; ADD 0x01 → C = 0x00, carry = 1, zero = 1. Then ADDC 0x00 → C = 0x01, carry = 0.
- SUB and shifts: LOAD 0x03; SUB 0x05 → C = 0xFE, carry = 0. Then SHR → C = 0x7F, carry = 0. Then SHL → C = 0xFE, carry = 0. Then SHL → C = 0xFC, carry = 1.
- MUL handshake: LOAD 0x0C; MUL 0x0B with op_valid held high and opcode switched to ADD 0x01 → busy and op_ready low for 8 cycles, C = 0x84 and carry = 0 at edge N+8, done pulses. The pending ADD is accepted only at N+9, giving C = 0x85.
- MUL overflow and abort:
  - LOAD 0x20; MUL 0x10 → C = 0x00, carry = 1, zero = 1.
  - LOAD 0x05; MUL 0x03; assert rst in the 3rd busy cycle → next cycle C = 0, busy = 0, op_ready = 1, and no write occurs at N+8.
- Undefined/idle:
  - LOAD 0x5A, set carry via SHL; then opcodes 0011, 0100, 1111 → C = 0xB4, carry = 0, overflow unchanged, done pulses each time.
  - op_valid = 0 for 5 cycles → no changes, done = 0.

Source files
------------

// File: rtl/acc_alu.sv
// acc_alu: WIDTH-bit accumulator ALU with carry/zero/overflow flags, a
// valid/ready request handshake and a multi-cycle shift-add multiply.
module acc_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] C,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_RESET = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_ADDC  = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_AND   = 4'b1001,
    OP_OR    = 4'b1010,
    OP_XOR   = 4'b1011,
    OP_NOT   = 4'b1100,
    OP_SHL   = 4'b1101,
    OP_SHR   = 4'b1110
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state;
  state_t             state_next;
  op_t                op;
  logic               accept;
  logic               mul_last;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_next;
  logic               carry_next;
  logic               ovf_next;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     addc_sum;
  logic [WIDTH-1:0]   sub_diff;

  assign op        = op_t'(opcode);
  assign busy      = (state == S_MUL);
  assign op_ready  = ~busy;
  assign accept    = op_valid && op_ready;
  assign zero      = (C == '0);
  assign mul_last  = (cnt == CW'(WIDTH - 1));
  assign prod_step = mplier[0] ? (prod + mcand) : prod;
  assign add_sum   = {1'b0, C} + {1'b0, A};
  assign addc_sum  = add_sum + {{WIDTH{1'b0}}, carry};
  assign sub_diff  = C - A;

  // Single-cycle result and flag update for the presented opcode.
  always_comb begin
    acc_next   = C;
    carry_next = carry;
    ovf_next   = overflow;
    case (op)
      OP_RESET: begin
        acc_next   = '0;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
      OP_LOAD: begin
        acc_next   = A;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
      OP_ADD: begin
        acc_next   = add_sum[WIDTH-1:0];
        carry_next = add_sum[WIDTH];
        ovf_next   = (C[MSB] == A[MSB]) && (add_sum[MSB] != C[MSB]);
      end
      OP_ADDC: begin
        acc_next   = addc_sum[WIDTH-1:0];
        carry_next = addc_sum[WIDTH];
        ovf_next   = (C[MSB] == A[MSB]) && (addc_sum[MSB] != C[MSB]);
      end
      OP_SUB: begin
        acc_next   = sub_diff;
        carry_next = (C >= A);
        ovf_next   = (C[MSB] != A[MSB]) && (sub_diff[MSB] != C[MSB]);
      end
      OP_AND: begin
        acc_next   = C & A;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
      OP_OR: begin
        acc_next   = C | A;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
      OP_XOR: begin
        acc_next   = C ^ A;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
      OP_NOT: begin
        acc_next = ~C;
        ovf_next = 1'b0;
      end
      OP_SHL: begin
        acc_next   = {C[WIDTH-2:0], 1'b0};
        carry_next = C[MSB];
        ovf_next   = 1'b0;
      end
      OP_SHR: begin
        acc_next   = {1'b0, C[WIDTH-1:1]};
        carry_next = C[0];
        ovf_next   = 1'b0;
      end
      default: ;
    endcase
  end

  // Multiply sequencing: enter on an accepted MUL, leave after WIDTH steps.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && (op == OP_MUL)) state_next = S_MUL;
      S_MUL:   if (mul_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Accumulator, flags, done pulse and shift-add multiplier datapath.
  // The final multiply step writes C from prod_step so the result lands on
  // the same edge as the last partial-product addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      C        <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= {{WIDTH{1'b0}}, C};
          mplier <= A;
          prod   <= '0;
          cnt    <= '0;
        end else begin
          C        <= acc_next;
          carry    <= carry_next;
          overflow <= ovf_next;
          done     <= 1'b1;
        end
      end else if (busy) begin
        prod   <= prod_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (mul_last) begin
          C        <= prod_step[WIDTH-1:0];
          carry    <= |prod_step[2*WIDTH-1:WIDTH];
          overflow <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_alu.sv
// Testbench for acc_alu: directed sequence plus a short random run; a
// behavioural model pushes expected results, a done-driven monitor pops them.
module tb_acc_alu;

  localparam int unsigned W = 8;

  localparam logic [3:0] NOOP = 4'h0, RSTOP = 4'h1, LOAD = 4'h2, ADD = 4'h5,
                         SUB = 4'h6, ADDC = 4'h7, MUL = 4'h8, ANDOP = 4'h9,
                         OROP = 4'hA, XOROP = 4'hB, NOTOP = 4'hC, SHL = 4'hD,
                         SHR = 4'hE;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   opcode;
  logic [W-1:0] A;
  logic [W-1:0] C;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;
  logic         done;

  acc_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .A        (A),
    .C        (C),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] c;
    logic         cy;
    logic         ov;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_c;
  logic         m_cy;
  logic         m_ov;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference model: integer arithmetic with range checks for overflow.
  task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a);
    int unsigned s;
    int          r;
    exp_t        e;
    case (op)
      RSTOP: begin m_c = '0; m_cy = 1'b0; m_ov = 1'b0; end
      LOAD:  begin m_c = a;  m_cy = 1'b0; m_ov = 1'b0; end
      ADD: begin
        s = int'(m_c) + int'(a);
        r = sgn(m_c) + sgn(a);
        m_c = W'(s); m_cy = (s >= (1 << W)); m_ov = (r > 127) || (r < -128);
      end
      ADDC: begin
        s = int'(m_c) + int'(a) + int'(m_cy);
        r = sgn(m_c) + sgn(a) + int'(m_cy);
        m_c = W'(s); m_cy = (s >= (1 << W)); m_ov = (r > 127) || (r < -128);
      end
      SUB: begin
        r = sgn(m_c) - sgn(a);
        m_cy = (m_c >= a);
        m_c  = W'(int'(m_c) - int'(a));
        m_ov = (r > 127) || (r < -128);
      end
      ANDOP: begin m_c = m_c & a; m_cy = 1'b0; m_ov = 1'b0; end
      OROP:  begin m_c = m_c | a; m_cy = 1'b0; m_ov = 1'b0; end
      XOROP: begin m_c = m_c ^ a; m_cy = 1'b0; m_ov = 1'b0; end
      NOTOP: begin m_c = ~m_c; m_ov = 1'b0; end
      SHL: begin m_cy = m_c[W-1]; m_c = W'(int'(m_c) * 2); m_ov = 1'b0; end
      SHR: begin m_cy = m_c[0];   m_c = W'(int'(m_c) / 2); m_ov = 1'b0; end
      MUL: begin
        s = int'(m_c) * int'(a);
        m_c = W'(s); m_cy = (s >= (1 << W)); m_ov = 1'b0;
      end
      default: ;
    endcase
    e.c = m_c; e.cy = m_cy; e.ov = m_ov;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    m_c = '0; m_cy = 1'b0; m_ov = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a);
    int n;
    opcode = op; A = a; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", 16'(op_ready), 16'(1));
    model_apply(op, a);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_timeout", 16'(busy), 16'(0));
  endtask

  // Scoreboard monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 16'(done), 16'(0));
      end else begin
        mon_e = sb.pop_front();
        check("C", 16'(C), 16'(mon_e.c));
        check("carry", 16'(carry), 16'(mon_e.cy));
        check("overflow", 16'(overflow), 16'(mon_e.ov));
        check("zero", 16'(zero), 16'(mon_e.c == '0));
      end
    end
  end

  initial begin
    logic [3:0] rop;
    logic [3:0] undef_ops[3];
    logic [W-1:0] hold_c;
    logic hold_cy, hold_ov;

    undef_ops[0] = 4'h3; undef_ops[1] = 4'h4; undef_ops[2] = 4'hF;
    rst = 1'b1; op_valid = 1'b1; opcode = LOAD; A = 8'h33;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("rst_C", 16'(C), 16'(0));
    check("rst_carry", 16'(carry), 16'(0));
    check("rst_ovf", 16'(overflow), 16'(0));
    check("rst_zero", 16'(zero), 16'(1));
    check("rst_busy", 16'(busy), 16'(0));
    check("rst_ready", 16'(op_ready), 16'(1));
    check("rst_done", 16'(done), 16'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Overflow, then flag preservation by NOOP/undefined, then AND clears.
    send(LOAD, 8'h7F);
    send(ADD, 8'h01);
    check("ovf_C", 16'(C), 16'(8'h80));
    check("ovf_flag", 16'(overflow), 16'(1));
    send(NOOP, 8'h00);
    send(4'hF, 8'h55);
    check("ovf_held", 16'(overflow), 16'(1));
    send(ANDOP, 8'h00);
    check("and_zero", 16'(zero), 16'(1));

    // Carry chain.
    send(LOAD, 8'hFF);
    send(ADD, 8'h01);
    check("chain_carry", 16'(carry), 16'(1));
    send(ADDC, 8'h00);
    check("addc_C", 16'(C), 16'(8'h01));

    // SUB and shifts.
    send(LOAD, 8'h03);
    send(SUB, 8'h05);
    check("sub_C", 16'(C), 16'(8'hFE));
    send(SHR, 8'h00);
    send(SHL, 8'h00);
    send(SHL, 8'h00);
    check("shl_C", 16'(C), 16'(8'hFC));
    check("shl_carry", 16'(carry), 16'(1));
    send(OROP, 8'h0F);
    send(XOROP, 8'hA5);
    send(NOTOP, 8'h00);
    send(RSTOP, 8'h00);

    // MUL handshake with a held request that must wait.
    send(LOAD, 8'h0C);
    opcode = MUL; A = 8'h0B; op_valid = 1'b1;
    model_apply(MUL, 8'h0B);
    @(posedge clk); #1;
    opcode = ADD; A = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check("mul_busy", 16'(busy), 16'(1));
      check("mul_ready", 16'(op_ready), 16'(0));
      check("mul_C_hold", 16'(C), 16'(8'h0C));
      @(posedge clk); #1;
    end
    check("mul_C", 16'(C), 16'(8'h84));
    check("mul_busy_drop", 16'(busy), 16'(0));
    check("mul_done", 16'(done), 16'(1));
    model_apply(ADD, 8'h01);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("pending_add_C", 16'(C), 16'(8'h85));

    // MUL with upper product bits set.
    send(LOAD, 8'h20);
    send(MUL, 8'h10);
    wait_idle();
    check("mul_ovf_C", 16'(C), 16'(8'h00));
    check("mul_ovf_carry", 16'(carry), 16'(1));

    // MUL abort by reset in the third busy cycle.
    send(LOAD, 8'h05);
    send(MUL, 8'h03);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_pre", 16'(busy), 16'(1));
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_C", 16'(C), 16'(0));
    check("abort_busy", 16'(busy), 16'(0));
    check("abort_ready", 16'(op_ready), 16'(1));
    for (int i = 0; i < 8; i++) begin
      check("abort_no_write", 16'(C), 16'(0));
      check("abort_no_done", 16'(done), 16'(0));
      @(posedge clk); #1;
    end

    // Undefined opcodes after a shift.
    send(LOAD, 8'h5A);
    send(SHL, 8'h00);
    for (int i = 0; i < 3; i++) begin
      send(undef_ops[i], W'($urandom));
      check("undef_done", 16'(done), 16'(1));
      check("undef_C", 16'(C), 16'(8'hB4));
      check("undef_carry", 16'(carry), 16'(0));
    end

    // Idle: op_valid low, other inputs wiggling.
    hold_c = C; hold_cy = carry; hold_ov = overflow;
    for (int i = 0; i < 5; i++) begin
      opcode = 4'($urandom); A = W'($urandom);
      @(posedge clk); #1;
      check("idle_C", 16'(C), 16'(hold_c));
      check("idle_carry", 16'(carry), 16'(hold_cy));
      check("idle_ovf", 16'(overflow), 16'(hold_ov));
      check("idle_done", 16'(done), 16'(0));
    end

    // Short random run across all opcodes.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom);
      send(rop, W'($urandom));
      if (rop == MUL) wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 16'(sb.size()), 16'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
